alu_issue_ctrl: RTL and testbench

//  Initiator side of the ALU interface: decodes the ALU op and funct fields into the 3-bit ALU control code.

---
 rtl/alu_issue_ctrl.sv | 158 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//   Initiator side of the ALU interface. Decodes alu_op/funct into a 3-bit ALU
//   control code, presents registered operands and code to a combinational
//   ALU, waits a fixed number of EXEC cycles (longer for mul), then captures
//   the ALU result and returns it over a valid/ready handshake.
//
// Ports
//   clk_i, rst_i                 clock (rising edge), async active-low reset
//   req_valid_i / req_ready_o    request handshake (ready only in IDLE)
//   alu_op_i, funct_i            operation select, {funct7,funct3}
//   data1_i, data2_i             operands, sampled only at accept
//   alu_data1_o/alu_data2_o      registered operands to the ALU
//   alu_ctrl_o                   registered control code to the ALU
//   alu_data_i, alu_zero_i       ALU result and zero flag
//   res_valid_o / res_ready_i    result handshake (valid only in DONE)
//   res_data_o, res_zero_o       captured result and zero flag
//   res_illegal_o                R-type funct was not recognised
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int unsigned ALU_LATENCY = 1,
    parameter int unsigned MUL_LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  alu_op_i,
    input  logic [9:0]  funct_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    output logic [31:0] alu_data1_o,
    output logic [31:0] alu_data2_o,
    output logic [2:0]  alu_ctrl_o,
    input  logic [31:0] alu_data_i,
    input  logic        alu_zero_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_data_o,
    output logic        res_zero_o,
    output logic        res_illegal_o
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    localparam logic [2:0] C_PASS = 3'b000;
    localparam logic [2:0] C_ADD  = 3'b001;
    localparam logic [2:0] C_SUB  = 3'b010;
    localparam logic [2:0] C_AND  = 3'b011;
    localparam logic [2:0] C_OR   = 3'b100;
    localparam logic [2:0] C_MUL  = 3'b101;

    // Counter preload is latency-1: the capture edge is the one where cnt==0.
    localparam logic [3:0] ALU_CNT = 4'(ALU_LATENCY - 1);
    localparam logic [3:0] MUL_CNT = 4'(MUL_LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] op1_q, op1_d, op2_q, op2_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        ill_q, ill_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rzero_q, rzero_d;

    logic [2:0]  dec_ctrl;
    logic        dec_ill;

    // Opcode/funct decode, used only at the accept edge.
    always_comb begin
        dec_ctrl = C_ADD;
        dec_ill  = 1'b0;
        case (alu_op_i)
            2'b01: dec_ctrl = C_SUB;
            2'b10: begin
                case (funct_i)
                    10'b0000000_000: dec_ctrl = C_ADD;
                    10'b0100000_000: dec_ctrl = C_SUB;
                    10'b0000000_111: dec_ctrl = C_AND;
                    10'b0000000_110: dec_ctrl = C_OR;
                    10'b0000001_000: dec_ctrl = C_MUL;
                    default: begin
                        dec_ctrl = C_PASS;
                        dec_ill  = 1'b1;
                    end
                endcase
            end
            default: dec_ctrl = C_ADD;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        ctrl_d  = ctrl_q;
        ill_d   = ill_q;
        rdata_d = rdata_q;
        rzero_d = rzero_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    op1_d   = data1_i;
                    op2_d   = data2_i;
                    ctrl_d  = dec_ctrl;
                    ill_d   = dec_ill;
                    cnt_d   = (dec_ctrl == C_MUL) ? MUL_CNT : ALU_CNT;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d = alu_data_i;
                    rzero_d = alu_zero_i;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            ctrl_q  <= '0;
            ill_q   <= 1'b0;
            rdata_q <= '0;
            rzero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            ctrl_q  <= ctrl_d;
            ill_q   <= ill_d;
            rdata_q <= rdata_d;
            rzero_q <= rzero_d;
        end
    end

    assign req_ready_o   = (state_q == S_IDLE);
    assign res_valid_o   = (state_q == S_DONE);
    assign alu_data1_o   = op1_q;
    assign alu_data2_o   = op2_q;
    assign alu_ctrl_o    = ctrl_q;
    assign res_data_o    = rdata_q;
    assign res_zero_o    = rzero_q;
    assign res_illegal_o = ill_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [1:0]  alu_op;
    logic [9:0]  funct;
    logic [31:0] data1, data2;
    logic [31:0] alu_d1, alu_d2;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic        res_zero, res_ill;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.ALU_LATENCY(1), .MUL_LATENCY(3)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .alu_op_i(alu_op), .funct_i(funct),
        .data1_i(data1), .data2_i(data2),
        .alu_data1_o(alu_d1), .alu_data2_o(alu_d2), .alu_ctrl_o(alu_ctrl),
        .alu_data_i(alu_res), .alu_zero_i(alu_zero),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_data_o(res_data), .res_zero_o(res_zero), .res_illegal_o(res_ill)
    );

    // Behavioural combinational ALU on the far side of the interface.
    always_comb begin
        alu_res = alu_d1;
        case (alu_ctrl)
            3'b001: alu_res = alu_d1 + alu_d2;
            3'b010: alu_res = alu_d1 - alu_d2;
            3'b011: alu_res = alu_d1 & alu_d2;
            3'b100: alu_res = alu_d1 | alu_d2;
            3'b101: alu_res = alu_d1 * alu_d2;
            default: alu_res = alu_d1;
        endcase
        alu_zero = (alu_res == 32'd0);
    end

    typedef struct {
        logic [1:0]  op;
        logic [9:0]  funct;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [2:0]  ctrl;
        logic [31:0] data;
        logic        zero;
        logic        ill;
        int          lat;
    } vec_t;

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] data;
        logic        zero;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one request, check latency and ready-low during the operation,
    // pop the scoreboard entry on res_valid, then complete the handshake.
    task automatic run_op(input vec_t v);
        exp_t e;
        exp_t got;
        int   lat;
        int   rdy_seen;
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
        alu_op = v.op; funct = v.funct; data1 = v.d1; data2 = v.d2;
        req_valid = 1'b1;
        @(posedge clk);
        e.ctrl = v.ctrl; e.data = v.data; e.zero = v.zero; e.ill = v.ill; e.lat = v.lat;
        sb.push_back(e);
        #1;
        req_valid = 1'b0;
        // Scramble inputs: they must have no effect after the accept edge.
        data1 = 32'h5A5A_A5A5; data2 = 32'h1234_5678; funct = 10'h2AA; alu_op = 2'b10;
        lat = 0;
        rdy_seen = 0;
        while (!res_valid && lat < 20) begin
            if (req_ready) rdy_seen++;
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, v.lat);
        chk("ready_low_exec", rdy_seen, 0);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            chk("alu_ctrl", {29'd0, alu_ctrl}, {29'd0, got.ctrl});
            chk("res_data", res_data, got.data);
            chk("res_zero", {31'd0, res_zero}, {31'd0, got.zero});
            chk("res_illegal", {31'd0, res_ill}, {31'd0, got.ill});
            chk("alu_data1", alu_d1, v.d1);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("valid_drop", {31'd0, res_valid}, 32'd0);
        chk("back_idle", {31'd0, req_ready}, 32'd1);
        chk("ctrl_hold_idle", {29'd0, alu_ctrl}, {29'd0, v.ctrl});
    endtask

    initial begin
        vec_t bp;
        logic [31:0] held;

        //          op     funct            d1            d2            ctrl    data          z     ill  lat
        vecs[0]  = '{2'b10, 10'b0000000_000, 32'd5,        32'd7,        3'b001, 32'd12,       1'b0, 1'b0, 1};
        vecs[1]  = '{2'b01, 10'b0000000_000, 32'd9,        32'd9,        3'b010, 32'd0,        1'b1, 1'b0, 1};
        vecs[2]  = '{2'b10, 10'b0000001_000, 32'd6,        32'd7,        3'b101, 32'd42,       1'b0, 1'b0, 3};
        vecs[3]  = '{2'b10, 10'b1111111_111, 32'hDEADBEEF, 32'd1,        3'b000, 32'hDEADBEEF, 1'b0, 1'b1, 1};
        vecs[4]  = '{2'b00, 10'b0000000_000, 32'd3,        32'd4,        3'b001, 32'd7,        1'b0, 1'b0, 1};
        vecs[5]  = '{2'b11, 10'b0000000_000, 32'hFFFFFFFF, 32'd1,        3'b001, 32'd0,        1'b1, 1'b0, 1};
        vecs[6]  = '{2'b10, 10'b0100000_000, 32'd20,       32'd5,        3'b010, 32'd15,       1'b0, 1'b0, 1};
        vecs[7]  = '{2'b10, 10'b0000000_111, 32'h0000F0F0, 32'h0000FF00, 3'b011, 32'h0000F000, 1'b0, 1'b0, 1};
        vecs[8]  = '{2'b10, 10'b0000000_110, 32'h0000F0F0, 32'h00000F00, 3'b100, 32'h0000FFF0, 1'b0, 1'b0, 1};
        vecs[9]  = '{2'b01, 10'b1111111_111, 32'd5,        32'd3,        3'b010, 32'd2,        1'b0, 1'b0, 1};
        vecs[10] = '{2'b10, 10'b0000001_001, 32'd77,       32'd2,        3'b000, 32'd77,       1'b0, 1'b1, 1};

        rst_n = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
        alu_op = 2'b00; funct = '0; data1 = '0; data2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_ctrl", {29'd0, alu_ctrl}, 32'd0);
        chk("rst_data", res_data, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_op(vecs[i]);

        // Reset in the middle of a multiply: operation is dropped.
        alu_op = 2'b10; funct = 10'b0000001_000; data1 = 32'd6; data2 = 32'd7;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mul_in_exec", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_valid", {31'd0, res_valid}, 32'd0);
        chk("midrst_ctrl", {29'd0, alu_ctrl}, 32'd0);
        chk("midrst_d1", alu_d1, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("postrst_valid", {31'd0, res_valid}, 32'd0);
        chk("postrst_ready", {31'd0, req_ready}, 32'd1);

        // Backpressure: hold res_ready low in DONE, wiggle inputs.
        bp = vecs[0];
        alu_op = bp.op; funct = bp.funct; data1 = bp.d1; data2 = bp.d2;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_valid", {31'd0, res_valid}, 32'd1);
        held = res_data;
        chk("bp_data", held, 32'd12);
        for (int k = 0; k < 4; k++) begin
            data1 = $urandom;
            req_valid = ~req_valid;
            @(posedge clk); #1;
            chk("bp_hold_valid", {31'd0, res_valid}, 32'd1);
            chk("bp_hold_data", res_data, 32'd12);
            chk("bp_no_accept", {31'd0, req_ready}, 32'd0);
            chk("bp_alu_d1", alu_d1, 32'd5);
        end
        res_ready = 1'b1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("bp_release_valid", {31'd0, res_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        chk("bp_still_idle", {31'd0, req_ready}, 32'd1);
        chk("bp_alu_hold", alu_d1, 32'd5);
        chk("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
